dcm_lock_ctrl: RTL and testbench

Lock supervisor and reset sequencer for the DCM clock divider. Runs on the free-running board clock that also feeds the DCM input. It drives the DCM's asynchronous active-high reset and watches its LOCKED output. It releases a clean system reset and a ready flag only after lock has been stable for a programmable time, and re-arms the DCM on lock timeout or lock loss.

---
 rtl/dcm_lock_ctrl.sv | 138 +++++++++++++
 tb/tb_dcm_lock_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_lock_ctrl.sv
// DCM lock supervisor and reset sequencer: pulses the DCM reset, waits for a
// stable synchronized lock, then releases sys_rst/ready; re-arms on timeout or loss.
module dcm_lock_ctrl #(
    parameter int RST_PULSE_CYCLES = 4,
    parameter int LOCK_TIMEOUT     = 50000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int CNT_W            = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       dcm_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic       lock_lost
);

    typedef enum logic [1:0] {
        RESET_DCM,
        WAIT_LOCK,
        STABILIZE,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_retry;
    logic             w_lost;

    logic             r_sync1;
    logic             r_lock_s;

    logic             r_dcm_rst;
    logic             r_sys_rst;
    logic             r_ready;
    logic [7:0]       r_retry_count;
    logic             r_lock_lost;

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    // locked is asynchronous to clk; only the second flop may reach the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= locked;
            r_lock_s <= r_sync1;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        w_next_state = r_state;
        w_next_cnt   = r_cnt + CNT_W'(1);
        w_retry      = 1'b0;
        w_lost       = 1'b0;
        case (r_state)
            RESET_DCM: begin
                if (r_cnt == RST_LAST) begin
                    w_next_state = WAIT_LOCK;
                    w_next_cnt   = '0;
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle still counts as acquired.
                if (r_lock_s) begin
                    w_next_state = STABILIZE;
                    w_next_cnt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_next_state = RESET_DCM;
                    w_next_cnt   = '0;
                    w_retry      = 1'b1;
                end
            end
            STABILIZE: begin
                if (!r_lock_s) begin
                    w_next_state = RESET_DCM;
                    w_next_cnt   = '0;
                    w_retry      = 1'b1;
                end else if (r_cnt == STABLE_LAST) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_next_cnt = r_cnt;
                if (!r_lock_s) begin
                    w_next_state = RESET_DCM;
                    w_next_cnt   = '0;
                    w_retry      = 1'b1;
                    w_lost       = 1'b1;
                end
            end
            default: begin
                w_next_state = RESET_DCM;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= RESET_DCM;
            r_cnt         <= '0;
            r_dcm_rst     <= 1'b1;
            r_sys_rst     <= 1'b1;
            r_ready       <= 1'b0;
            r_retry_count <= 8'd0;
            r_lock_lost   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_dcm_rst <= (w_next_state == RESET_DCM);
            r_sys_rst <= (w_next_state != RUN);
            r_ready   <= (w_next_state == RUN);
            if (w_retry && (r_retry_count != 8'hFF)) begin
                r_retry_count <= r_retry_count + 8'd1;
            end
            if (w_lost) begin
                r_lock_lost <= 1'b1;
            end
        end
    end

    assign dcm_rst     = r_dcm_rst;
    assign sys_rst     = r_sys_rst;
    assign ready       = r_ready;
    assign retry_count = r_retry_count;
    assign lock_lost   = r_lock_lost;

endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// Self-checking bench for dcm_lock_ctrl: bring-up table, directed corner sequences,
// and randomized lock activity against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_dcm_lock_ctrl;

    localparam int RST_PULSE = 4;
    localparam int TIMEOUT   = 100;
    localparam int STABLE    = 16;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       dcm_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] retry_count;
    logic       lock_lost;

    int n_cmp = 0;
    int n_err = 0;

    dcm_lock_ctrl #(
        .RST_PULSE_CYCLES(RST_PULSE),
        .LOCK_TIMEOUT    (TIMEOUT),
        .STABLE_CYCLES   (STABLE),
        .CNT_W           (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .locked     (locked),
        .dcm_rst    (dcm_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .retry_count(retry_count),
        .lock_lost  (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference model: phase plus timestamp of phase entry; durations are edge differences.
    typedef enum int {HOLD_DCM, HUNT, SETTLE, LIVE} phase_t;
    phase_t m_ph;
    int     m_k;
    int     m_t0;
    int     m_retry;
    logic   m_lost;
    logic   hist[$];

    function automatic logic [11:0] vec(input logic d, input logic s, input logic r,
                                        input logic l, input logic [7:0] c);
        return {d, s, r, l, c};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {dcm_rst, sys_rst, ready, lock_lost, retry_count};
    endfunction

    function automatic logic [11:0] model_vec();
        return {m_ph == HOLD_DCM, m_ph != LIVE, m_ph == LIVE, m_lost, 8'(m_retry)};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got {dcm,sys,rdy,lost,retry}=%b_%h expected %b_%h",
                     name, m_k, act[11:8], act[7:0], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic model_reset();
        m_ph    = HOLD_DCM;
        m_k     = 0;
        m_t0    = 0;
        m_retry = 0;
        m_lost  = 1'b0;
        hist.delete();
    endtask

    task automatic bump_retry();
        if (m_retry < 255) m_retry++;
    endtask

    task automatic model_step(input logic lk);
        logic ls;
        int   el;
        hist.push_back(lk);
        ls = (hist.size() == 3) ? hist.pop_front() : 1'b0;
        m_k++;
        el = m_k - m_t0;
        case (m_ph)
            HOLD_DCM: if (el == RST_PULSE) begin m_ph = HUNT; m_t0 = m_k; end
            HUNT: begin
                if (ls) begin m_ph = SETTLE; m_t0 = m_k; end
                else if (el == TIMEOUT) begin m_ph = HOLD_DCM; m_t0 = m_k; bump_retry(); end
            end
            SETTLE: begin
                if (!ls) begin m_ph = HOLD_DCM; m_t0 = m_k; bump_retry(); end
                else if (el == STABLE) begin m_ph = LIVE; m_t0 = m_k; end
            end
            LIVE: if (!ls) begin m_ph = HOLD_DCM; m_t0 = m_k; bump_retry(); m_lost = 1'b1; end
            default: ;
        endcase
    endtask

    // Starts and ends at a falling edge; one rising edge per call, compared against the model.
    task automatic tick(input logic lk);
        locked = lk;
        @(posedge clk);
        model_step(lk);
        #1;
        check("model", dut_vec(), model_vec());
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        locked = 1'b0;
        model_reset();
        #1;
        check("reset_state", dut_vec(), vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int          edge_n;
        logic        lk;
        logic [11:0] exp;
    } bringup_t;

    bringup_t tbl[9];

    initial begin
        rst    = 1'b0;
        locked = 1'b0;
        model_reset();

        // Normal bring-up: locked first sampled at edge 24 (20 cycles after dcm_rst falls).
        tbl[0] = '{1,  1'b0, vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0)};
        tbl[1] = '{3,  1'b0, vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0)};
        tbl[2] = '{4,  1'b0, vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0)};
        tbl[3] = '{23, 1'b0, vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0)};
        tbl[4] = '{24, 1'b1, vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0)};
        tbl[5] = '{26, 1'b1, vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0)};
        tbl[6] = '{41, 1'b1, vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0)};
        tbl[7] = '{42, 1'b1, vec(1'b0, 1'b0, 1'b1, 1'b0, 8'd0)};
        tbl[8] = '{60, 1'b1, vec(1'b0, 1'b0, 1'b1, 1'b0, 8'd0)};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            while (m_k < tbl[i].edge_n) tick(tbl[i].lk);
            check($sformatf("bringup_e%0d", tbl[i].edge_n), dut_vec(), tbl[i].exp);
        end

        // Lock loss in RUN: low samples at edges 61..63, then restored.
        tick(1'b0);
        tick(1'b0);
        check("loss_e_plus1", dut_vec(), vec(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
        tick(1'b0);
        check("loss_e_plus2", dut_vec(), vec(1'b1, 1'b1, 1'b0, 1'b1, 8'd1));
        for (int i = 0; i < 40; i++) tick(1'b1);
        check("loss_resequenced", dut_vec(), vec(1'b0, 1'b0, 1'b1, 1'b1, 8'd1));

        // Timeout retry with locked held low, then saturation.
        do_reset();
        while (m_k < 103) tick(1'b0);
        check("timeout_e103", dut_vec(), vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        tick(1'b0);
        check("timeout_e104", dut_vec(), vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
        while (m_k < 107) tick(1'b0);
        check("timeout_e107", dut_vec(), vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
        tick(1'b0);
        check("timeout_e108", dut_vec(), vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
        while (m_k < 207) tick(1'b0);
        check("timeout_e207", dut_vec(), vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
        tick(1'b0);
        check("timeout_e208", dut_vec(), vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd2));
        while (m_k < 26_800) tick(1'b0);
        check("retry_saturated", {4'b0, retry_count}, 12'd255);

        // Unstable lock: high for 10 samples from edge 10, drop sampled at edge 20.
        do_reset();
        while (m_k < 9) tick(1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        check("unstable_d_plus1", dut_vec(), vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        tick(1'b0);
        check("unstable_d_plus2", dut_vec(), vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
        for (int i = 0; i < 30; i++) tick(1'b0);

        // Boundary: lock_s first high on the timeout cycle (edge 104).
        do_reset();
        while (m_k < 101) tick(1'b0);
        while (m_k < 104) tick(1'b1);
        check("lock_on_timeout", dut_vec(), vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        while (m_k < 119) tick(1'b1);
        check("lock_on_timeout_e119", dut_vec(), vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        tick(1'b1);
        check("lock_on_timeout_run", dut_vec(), vec(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));

        // Boundary: lock_s drops on the final STABILIZE cycle (edge 28).
        do_reset();
        while (m_k < 9) tick(1'b0);
        for (int i = 0; i < 16; i++) tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        check("drop_on_last_e27", dut_vec(), vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        tick(1'b0);
        check("drop_on_last_e28", dut_vec(), vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd1));

        // Async reset mid-STABILIZE (cnt=8 after edge 120), after one earlier retry.
        do_reset();
        while (m_k < 109) tick(1'b0);
        while (m_k < 120) tick(1'b1);
        check("pre_async_reset", dut_vec(), vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
        rst = 1'b0;
        #1;
        check("async_reset_no_edge", dut_vec(), vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        model_reset();
        @(negedge clk);
        check("async_reset_held", dut_vec(), vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        rst = 1'b1;
        for (int i = 0; i < 22; i++) tick(1'b1);
        check("restart_run", dut_vec(), vec(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));

        // Randomized lock activity, including single-cycle glitches.
        do_reset();
        for (int b = 0; b < 80; b++) begin
            logic lk;
            int   len;
            lk  = 1'($urandom_range(0, 1));
            len = lk ? int'($urandom_range(1, 50)) : int'($urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) len = 1;
            for (int i = 0; i < len; i++) tick(lk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
